instr_encoder: RTL and testbench

Sequential instruction encoder: the inverse of the main control decoder. It accepts one operation request at a time over a valid/ready handshake and packs it into a 32-bit instruction word using the decoder's opcode map. It then writes the word into instruction memory at an auto-incrementing address. It sits in the test/boot path and loads programs ahead of the single-cycle datapath.

---
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs operation requests into 32-bit instruction words and streams them into
// instruction memory at consecutive word addresses until end-of-program or full.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ack,
    output logic [ADDR_W:0]   instr_count,
    output logic              err_illegal,
    output logic              done
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_illegal;
    logic              w_ack;

    assign w_accept = req_valid && (r_state == S_IDLE);
    // Ack only counts while a write is actually being presented.
    assign w_ack    = im_ack && (r_state == S_WRITE);

    always_comb begin
        w_state_next = r_state;
        w_word       = r_wdata;
        w_illegal    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_kind)
                        3'd0: begin
                            w_word       = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, req_funct};
                            w_state_next = S_WRITE;
                        end
                        3'd1: begin
                            w_word       = {6'b001100, req_rs, req_rt, req_imm};
                            w_state_next = S_WRITE;
                        end
                        3'd2: begin
                            w_word       = {6'b001101, req_rs, req_rt, req_imm};
                            w_state_next = S_WRITE;
                        end
                        3'd3: begin
                            w_word       = {6'b010000, req_rs, req_rt, req_imm};
                            w_state_next = S_WRITE;
                        end
                        3'd4: begin
                            w_word       = {6'b010001, req_rs, req_rt, req_imm};
                            w_state_next = S_WRITE;
                        end
                        3'd5: w_state_next = S_DONE;
                        default: w_illegal = 1'b1;
                    endcase
                end
            end
            S_WRITE: begin
                if (im_ack) begin
                    w_state_next = (r_addr == ADDR_LAST) ? S_DONE : S_IDLE;
                end
            end
            default: w_state_next = S_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wdata <= '0;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept && (w_state_next == S_WRITE)) begin
                r_wdata <= w_word;
            end
            if (w_accept && w_illegal) begin
                r_err <= 1'b1;
            end
            if (w_ack) begin
                r_count <= r_count + 1'b1;
                // The last address is held so the memory never wraps to word 0.
                if (r_addr != ADDR_LAST) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE) && !rst;
    assign im_we       = (r_state == S_WRITE);
    assign im_addr     = r_addr;
    assign im_wdata    = r_wdata;
    assign instr_count = r_count;
    assign err_illegal = r_err;
    assign done        = (r_state == S_DONE);
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: vector table for encodings plus hand-built
// sequences for ack stalls, illegal/end requests, memory-full and reset mid-write.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid2 = 1'b0;
    logic [2:0]  req_kind = '0;
    logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
    logic [5:0]  req_funct = '0;
    logic [15:0] req_imm = '0;
    logic        im_ack = 1'b0;

    logic        req_ready, im_we, err_illegal, done;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic [8:0]  instr_count;

    logic        req_ready2, im_we2, err_illegal2, done2;
    logic [1:0]  im_addr2;
    logic [31:0] im_wdata2;
    logic [2:0]  instr_count2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .im_ack(im_ack), .instr_count(instr_count),
        .err_illegal(err_illegal), .done(done)
    );

    instr_encoder #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_kind(req_kind), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_funct(req_funct), .req_imm(req_imm), .im_we(im_we2), .im_addr(im_addr2),
        .im_wdata(im_wdata2), .im_ack(im_ack), .instr_count(instr_count2),
        .err_illegal(err_illegal2), .done(done2)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else begin
            passed++;
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req_valid2 = 1'b0;
        im_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // One-cycle request pulse; fields are scrambled afterwards to prove latching.
    task automatic issue(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
        req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_funct = f; req_imm = imm;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_rs = ~rs; req_rt = ~rt; req_rd = ~rd; req_funct = ~f; req_imm = ~imm;
    endtask

    initial begin
        int nwrites;
        vecs[0] = '{3'd0, 5'd1,  5'd2, 5'd3,  6'h20, 16'h0000, 32'h00221820};
        vecs[1] = '{3'd1, 5'd2,  5'd3, 5'd0,  6'h00, 16'h0005, 32'h30430005};
        vecs[2] = '{3'd2, 5'd5,  5'd5, 5'd0,  6'h00, 16'h0001, 32'h34A50001};
        vecs[3] = '{3'd0, 5'd31, 5'd0, 5'd31, 6'h3F, 16'h0000, 32'h03E0F83F};
        vecs[4] = '{3'd1, 5'd1,  5'd1, 5'd31, 6'h3F, 16'h8000, 32'h30218000};

        // Reset state
        rst = 1'b1;
        step();
        chk("ready_in_rst", {31'd0, req_ready}, 32'd0);
        do_reset();
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_we", {31'd0, im_we}, 32'd0);
        chk("rst_addr", {24'd0, im_addr}, 32'd0);
        chk("rst_wdata", im_wdata, 32'd0);
        chk("rst_count", {23'd0, instr_count}, 32'd0);
        chk("rst_err", {31'd0, err_illegal}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Table: encodings with im_ack tied high
        im_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct, vecs[i].imm);
            chk($sformatf("v%0d_we", i), {31'd0, im_we}, 32'd1);
            chk($sformatf("v%0d_busy", i), {31'd0, req_ready}, 32'd0);
            chk($sformatf("v%0d_addr", i), {24'd0, im_addr}, i);
            chk($sformatf("v%0d_wdata", i), im_wdata, vecs[i].exp);
            step();
            chk($sformatf("v%0d_we_drop", i), {31'd0, im_we}, 32'd0);
            chk($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
            chk($sformatf("v%0d_count", i), {23'd0, instr_count}, i + 1);
            chk($sformatf("v%0d_addr_inc", i), {24'd0, im_addr}, i + 1);
        end

        // lw with ack held off for 3 cycles, then sw
        do_reset();
        issue(3'd4, 5'd0, 5'd4, 5'd9, 6'h11, 16'hFFFC);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lw_we_c%0d", k), {31'd0, im_we}, 32'd1);
            chk($sformatf("lw_wdata_c%0d", k), im_wdata, 32'h4404FFFC);
            chk($sformatf("lw_addr_c%0d", k), {24'd0, im_addr}, 32'd0);
            chk($sformatf("lw_count_c%0d", k), {23'd0, instr_count}, 32'd0);
            im_ack = (k == 3);
            step();
        end
        im_ack = 1'b0;
        chk("lw_we_drop", {31'd0, im_we}, 32'd0);
        chk("lw_count", {23'd0, instr_count}, 32'd1);
        im_ack = 1'b1;
        issue(3'd3, 5'd29, 5'd31, 5'd0, 6'h00, 16'h0008);
        chk("sw_wdata", im_wdata, 32'h43BF0008);
        chk("sw_addr", {24'd0, im_addr}, 32'd1);
        step();
        chk("sw_count", {23'd0, instr_count}, 32'd2);

        // Illegal kind, then end-of-program
        do_reset();
        im_ack = 1'b1;
        issue(3'd6, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001);
        chk("ill_err", {31'd0, err_illegal}, 32'd1);
        chk("ill_ready", {31'd0, req_ready}, 32'd1);
        chk("ill_we", {31'd0, im_we}, 32'd0);
        issue(3'd7, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001);
        chk("ill7_we", {31'd0, im_we}, 32'd0);
        issue(3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000);
        chk("end_done", {31'd0, done}, 32'd1);
        chk("end_ready", {31'd0, req_ready}, 32'd0);
        chk("end_we", {31'd0, im_we}, 32'd0);
        for (int k = 0; k < 3; k++) issue(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000);
        chk("end_ignore_we", {31'd0, im_we}, 32'd0);
        chk("end_ignore_count", {23'd0, instr_count}, 32'd0);
        chk("end_still_done", {31'd0, done}, 32'd1);
        chk("end_err_sticky", {31'd0, err_illegal}, 32'd1);

        // Memory full on the 4-word instance with back-to-back addi requests
        do_reset();
        im_ack = 1'b1;
        req_kind = 3'd1; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd0;
        req_funct = 6'h00; req_imm = 16'h0007;
        req_valid2 = 1'b1;
        nwrites = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (im_we2) begin
                chk($sformatf("full_addr_w%0d", nwrites), {30'd0, im_addr2}, nwrites);
                chk($sformatf("full_wdata_w%0d", nwrites), im_wdata2, 32'h30220007);
                nwrites++;
            end
        end
        req_valid2 = 1'b0;
        chk("full_nwrites", nwrites, 32'd4);
        chk("full_count", {29'd0, instr_count2}, 32'd4);
        chk("full_done", {31'd0, done2}, 32'd1);
        chk("full_ready", {31'd0, req_ready2}, 32'd0);
        chk("full_addr_hold", {30'd0, im_addr2}, 32'd3);

        // Reset while a write is pending and acked in the same cycle
        do_reset();
        im_ack = 1'b0;
        issue(3'd1, 5'd2, 5'd3, 5'd0, 6'h00, 16'h0005);
        chk("rw_we", {31'd0, im_we}, 32'd1);
        rst = 1'b1;
        im_ack = 1'b1;
        step();
        chk("rw_we_after", {31'd0, im_we}, 32'd0);
        chk("rw_count", {23'd0, instr_count}, 32'd0);
        chk("rw_addr", {24'd0, im_addr}, 32'd0);
        chk("rw_wdata", im_wdata, 32'd0);
        rst = 1'b0;
        im_ack = 1'b0;
        #1;
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("rw_count_later", {23'd0, instr_count}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
